sqed_inst_encoder: RTL
======================

# sqed_inst_encoder

Generates the legal RV64G instruction stream for SQED runs from compact per-instruction requests. Each accepted request is encoded into a 32-bit word that meets the SQED instruction constraints. The original uses registers 0–15. When QED mode is on, the block then emits the duplicate, which uses registers 16–31 and the upper memory half. It sits between the stimulus source and the core fetch interface and drives the stall NOP whenever it has nothing to issue.

## Interface
- Parameters
- CNT_W, 16, width of the issued-instruction counter
- Ports
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- qed_en  input  1  1 = emit a duplicate after each original; sampled at request accept
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_op  input  6  op code: 0–13 ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,MUL,MULH,MULHSU,MULHU; 14–22 ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI; 23 LW; 24 SW; 25–36 FLW,FSW,FADD.S,FSUB.S,FMUL.S,FDIV.S,FSQRT.S,FMIN.S,FMAX.S,FEQ.S,FLT.S,FLE.S; 37–48 same order for .D
- req_rd, req_rs1, req_rs2  input  4 each  architectural register indices 0–15
- req_imm  input  12  immediate; shift amount is imm[5:0]
- req_rm  input  3  FP funct3 for FADD/FSUB/FMUL/FDIV/FSQRT
- out_valid  output  1  out_inst is a real instruction
- out_ready  input  1  consumer takes out_inst this cycle
- out_inst  output  32  instruction word; 32'h0000007F (stall NOP) when out_valid=0
- out_dup  output  1  current out_inst is a duplicate
- err  output  1  one-cycle pulse: last accepted request was illegal
- inst_cnt  output  CNT_W  count of issued words, originals plus duplicates; wraps

## Operation
- FSM states: IDLE, ORIG, DUP. req_ready=1 only in IDLE.
- IDLE with req_valid: latch all fields and qed_en. If the request is legal, go to ORIG; otherwise stay in IDLE and pulse err on the next cycle.
- ORIG: out_valid=1, out_dup=0. On out_ready, go to DUP if latched qed_en=1, else to IDLE.
- DUP: out_valid=1, out_dup=1. On out_ready, go to IDLE.
- out_inst, out_dup and out_valid are held stable while out_valid=1 and out_ready=0.
- inst_cnt increments on every out_valid&&out_ready and wraps from all-ones to 0.
- Encoding, R ALU: opcode 0110011. funct7 is 0000000, or 0100000 for SUB/SRA, or 0000001 for MUL*. funct3 follows standard RV order.
- Encoding, I ALU: opcode 0010011, imm[11:0] in bits [31:20].
- Shifts: [31:26] is 000000 for SLLI/SRLI and 010000 for SRAI. [25:20] is imm[5:0].
- LW/FLW/FLD: rs1=x0, [31:25]=0, [24:20]=imm[4:0]. funct3 is 010 for W and 011 for D. Opcode is 0000011 for LW and 0000111 for FLW/FLD.
- SW/FSW/FSD: rs1=x0, [31:25]=0, [11:7]=imm[4:0], rs2 field = req_rs2. Opcode is 0100011 for SW and 0100111 for FSW/FSD.
- FP ops: opcode 1010011. funct7 is S/D base with bit 25=1 for .D: ADD 000000x, SUB 000010x, MUL 000100x, DIV 000110x, SQRT 010110x, MIN/MAX 001010x, cmp 101000x.
- FP funct3: req_rm for arithmetic ops. Fixed for the rest: MIN 000, MAX 001, FEQ 010, FLT 001, FLE 000.
- FSQRT: rs2 field forced to 0.
- Duplicate: the original word with bit 4 set in every register field except forced-zero fields (memory rs1, FSQRT rs2). Memory ops also set imm[4].
- Illegal: req_op>48. Memory op with req_imm[11:5]≠0 or req_imm[4]=1. FP arithmetic with req_rm>4. Shift with imm[11:6]≠0.

## Timing
- Reset (asynchronous): state IDLE, req_ready=1, out_valid=0, out_dup=0, out_inst=32'h0000007F, err=0, inst_cnt=0.
- Reset mid-operation discards the pending instruction; no partial duplicate is issued.
- Latency: request accepted at cycle N; original valid at N+1; duplicate valid on the cycle after the original handshake.
- Throughput with out_ready held high: 2 cycles per request without QED, 3 cycles with QED.
- err is asserted at N+1 only, and out_valid stays 0 for that request.
- qed_en changes take effect only at the next accept.

## Test plan
- ADD rd=1 rs1=2 rs2=3, qed_en=1, out_ready=1 -> out_inst 32'h003100B3 (dup=0), then 32'h013908B3 (dup=1); inst_cnt=2.
- LW rd=5 imm=3, qed_en=1 -> 32'h00302283, then 32'h01302A83.
- SRAI rd=1 rs1=1 imm=40, out_ready low 3 cycles then high -> 32'h4280D093 held stable, then dup 32'h4288D893.
- FSQRT.D rd=2 rs1=4 rs2=7 rm=0, qed_en=0 -> only 32'h5A020153; req_ready returns next cycle.
- FADD.S rm=5, then LW imm=16 -> err pulses one cycle for each, out_valid stays 0, out_inst=32'h0000007F.
- rst_n low while in DUP -> out_valid=0 immediately; after release, the next request starts with an original; inst_cnt=0.

Source files
------------

// File: rtl/sqed_inst_encoder_if.sv
// Request/issue bundle for the SQED instruction encoder.
//   req_*  : compact per-instruction request from the stimulus source
//   out_*  : encoded instruction handed to the core fetch interface
// master : stimulus source / fetch consumer side
// slave  : the encoder itself
`timescale 1ns/1ps
interface sqed_inst_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [3:0]  req_rd;
  logic [3:0]  req_rs1;
  logic [3:0]  req_rs2;
  logic [11:0] req_imm;
  logic [2:0]  req_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_dup;

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, req_rm, out_ready,
    input  req_ready, out_valid, out_inst, out_dup
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, req_rm, out_ready,
    output req_ready, out_valid, out_inst, out_dup
  );
endinterface

// File: rtl/sqed_inst_encoder.sv
// SQED instruction encoder: turns compact requests into legal RV64G words.
// The original uses x0-x15/f0-f15 and the lower memory half; with QED mode on
// a duplicate follows using x16-x31/f16-f31 and the upper memory half.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   qed_en     : emit a duplicate after each original (sampled at accept)
//   bus        : request (req_*) and issue (out_*) handshakes
//   err        : one-cycle pulse after an illegal request is accepted
//   inst_cnt   : wrapping count of issued words (originals + duplicates)
`timescale 1ns/1ps
module sqed_inst_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 qed_en,
  sqed_inst_encoder_if.slave   bus,
  output logic                 err,
  output logic [CNT_W-1:0]     inst_cnt
);

  localparam logic [31:0] STALL_NOP = 32'h0000007F;

  typedef enum logic [1:0] {IDLE, ORIG, DUP} state_t;

  state_t      state_q, state_d;
  logic [31:0] orig_q, dup_q;
  logic        qed_q;
  logic        accept, issue, req_legal;

  function automatic logic is_legal(input logic [5:0] op, input logic [11:0] imm,
                                    input logic [2:0] rm);
    logic mem, fp_arith, shift;
    mem      = (op == 6'd23) || (op == 6'd24) || (op == 6'd25) || (op == 6'd26) ||
               (op == 6'd37) || (op == 6'd38);
    fp_arith = ((op >= 6'd27) && (op <= 6'd31)) || ((op >= 6'd39) && (op <= 6'd43));
    shift    = (op >= 6'd20) && (op <= 6'd22);
    is_legal = (op <= 6'd48) &&
               !(mem && (imm[11:4] != '0)) &&
               !(fp_arith && (rm > 3'd4)) &&
               !(shift && (imm[11:6] != '0));
  endfunction

  // dup=1 sets bit 4 of every register field and of the memory offset;
  // forced-zero fields (memory rs1, FSQRT rs2) are built from literals instead.
  function automatic logic [31:0] encode(input logic [5:0] op, input logic [3:0] rd,
                                         input logic [3:0] rs1, input logic [3:0] rs2,
                                         input logic [11:0] imm, input logic [2:0] rm,
                                         input logic dup);
    logic [4:0]  frd, frs1, frs2, fimm;
    logic [6:0]  f7;
    logic [5:0]  f6;
    logic [2:0]  f3, fw3;
    logic [5:0]  fi;
    logic        dbl;
    logic [31:0] w;
    frd  = {dup, rd};
    frs1 = {dup, rs1};
    frs2 = {dup, rs2};
    fimm = {imm[4] | dup, imm[3:0]};
    f7   = '0;
    f6   = '0;
    f3   = '0;
    fi   = '0;
    dbl  = 1'b0;
    fw3  = 3'b010;
    w    = STALL_NOP;
    if (op <= 6'd13) begin
      case (op)
        6'd0:  f3 = 3'b000;
        6'd1:  begin f3 = 3'b000; f7 = 7'b0100000; end
        6'd2:  f3 = 3'b001;
        6'd3:  f3 = 3'b010;
        6'd4:  f3 = 3'b011;
        6'd5:  f3 = 3'b100;
        6'd6:  f3 = 3'b101;
        6'd7:  begin f3 = 3'b101; f7 = 7'b0100000; end
        6'd8:  f3 = 3'b110;
        6'd9:  f3 = 3'b111;
        6'd10: begin f3 = 3'b000; f7 = 7'b0000001; end
        6'd11: begin f3 = 3'b001; f7 = 7'b0000001; end
        6'd12: begin f3 = 3'b010; f7 = 7'b0000001; end
        default: begin f3 = 3'b011; f7 = 7'b0000001; end
      endcase
      w = {f7, frs2, frs1, f3, frd, 7'b0110011};
    end else if (op <= 6'd22) begin
      case (op)
        6'd14: f3 = 3'b000;
        6'd15: f3 = 3'b010;
        6'd16: f3 = 3'b011;
        6'd17: f3 = 3'b100;
        6'd18: f3 = 3'b110;
        6'd19: f3 = 3'b111;
        6'd20: f3 = 3'b001;
        default: f3 = 3'b101;
      endcase
      if (op >= 6'd20)
        w = {((op == 6'd22) ? 6'b010000 : 6'b000000), imm[5:0], frs1, f3, frd, 7'b0010011};
      else
        w = {imm, frs1, f3, frd, 7'b0010011};
    end else if (op == 6'd23) begin
      w = {7'b0, fimm, 5'b0, 3'b010, frd, 7'b0000011};
    end else if (op == 6'd24) begin
      w = {7'b0, frs2, 5'b0, 3'b010, fimm, 7'b0100011};
    end else if (op <= 6'd48) begin
      dbl = (op >= 6'd37);
      fi  = dbl ? (op - 6'd37) : (op - 6'd25);
      fw3 = dbl ? 3'b011 : 3'b010;
      case (fi)
        6'd2:  begin f6 = 6'b000000; f3 = rm; end
        6'd3:  begin f6 = 6'b000010; f3 = rm; end
        6'd4:  begin f6 = 6'b000100; f3 = rm; end
        6'd5:  begin f6 = 6'b000110; f3 = rm; end
        6'd6:  begin f6 = 6'b010110; f3 = rm; frs2 = '0; end
        6'd7:  begin f6 = 6'b001010; f3 = 3'b000; end
        6'd8:  begin f6 = 6'b001010; f3 = 3'b001; end
        6'd9:  begin f6 = 6'b101000; f3 = 3'b010; end
        6'd10: begin f6 = 6'b101000; f3 = 3'b001; end
        default: begin f6 = 6'b101000; f3 = 3'b000; end
      endcase
      if (fi == 6'd0)
        w = {7'b0, fimm, 5'b0, fw3, frd, 7'b0000111};
      else if (fi == 6'd1)
        w = {7'b0, frs2, 5'b0, fw3, fimm, 7'b0100111};
      else
        w = {f6, dbl, frs2, frs1, f3, frd, 7'b1010011};
    end
    encode = w;
  endfunction

  assign req_legal = is_legal(bus.req_op, bus.req_imm, bus.req_rm);
  assign accept    = (state_q == IDLE) && bus.req_valid;
  assign issue     = bus.out_valid && bus.out_ready;

  // Both words are built at accept so the issue path is a plain register mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      orig_q   <= STALL_NOP;
      dup_q    <= STALL_NOP;
      qed_q    <= 1'b0;
      err      <= 1'b0;
      inst_cnt <= '0;
    end else begin
      state_q <= state_d;
      err     <= accept && !req_legal;
      if (accept) begin
        orig_q <= encode(bus.req_op, bus.req_rd, bus.req_rs1, bus.req_rs2,
                         bus.req_imm, bus.req_rm, 1'b0);
        dup_q  <= encode(bus.req_op, bus.req_rd, bus.req_rs1, bus.req_rs2,
                         bus.req_imm, bus.req_rm, 1'b1);
        qed_q  <= qed_en;
      end
      if (issue) inst_cnt <= inst_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_dup   = 1'b0;
    bus.out_inst  = STALL_NOP;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid && req_legal) state_d = ORIG;
      end
      ORIG: begin
        bus.out_valid = 1'b1;
        bus.out_inst  = orig_q;
        if (bus.out_ready) state_d = qed_q ? DUP : IDLE;
      end
      DUP: begin
        bus.out_valid = 1'b1;
        bus.out_dup   = 1'b1;
        bus.out_inst  = dup_q;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
